traffic_lights_cfg_seq: RTL
===========================

// Module: traffic_lights_cfg_seq
// PURPOSE
//  Command sequencer/arbiter in front of traffic_lights; sole driver of its cmd_type/cmd_valid/cmd_data.
//  Shares the command port between an operator command source and an atomic timing-update request.
//  Timing updates expand into: enter YELLOW_MANUAL, set green/red/yellow, restore previous mode.
//  Tracks the controller mode from the commands it issues, so updates restore OFF/MANUAL/NORMAL correctly.
// PARAMETERS
//  CMD_GAP   1   idle cycles forced after every issued command (>=0)
//  DATA_W    16  width of time fields and cmd_data
// PORTS
//  clk_i         in   1       clock (2 kHz system clock)
//  arst_i        in   1       reset, asynchronous, active-high
//  op_valid_i    in   1       operator command request
//  op_ready_o    out  1       operator command accepted when valid&ready
//  op_type_i     in   3       operator command type (0..7)
//  op_data_i     in   DATA_W  operator command data
//  cfg_valid_i   in   1       timing-update request
//  cfg_ready_o   out  1       timing update accepted when valid&ready
//  cfg_green_i   in   DATA_W  new green time, cycles
//  cfg_red_i     in   DATA_W  new red time, cycles
//  cfg_yellow_i  in   DATA_W  new yellow time, cycles
//  cmd_valid_o   out  1       to traffic_lights cmd_valid_i; one-cycle pulse, registered
//  cmd_type_o    out  3       to traffic_lights cmd_type_i, registered
//  cmd_data_o    out  DATA_W  to traffic_lights cmd_data_i, registered
//  busy_o        out  1       sequence or gap in progress
//  done_o        out  1       one-cycle pulse: timing update finished
//  err_o         out  1       one-cycle pulse: operator type 6/7 accepted and dropped
// BEHAVIOUR
//  Reset (async): state IDLE, mode NORMAL, RR pointer -> op, shadows = 10; all outputs 0 except op_ready_o/cfg_ready_o = 1.
//  Ready: op_ready_o / cfg_ready_o high only in IDLE, gated by the arbiter. Inputs are sampled at accept.
//  Arbitration: 2-way round robin. When both are valid, the pointer side wins; after any grant the pointer goes to the other side.
//  Operator path: accept at N -> cmd_valid_o at N+1 with type/data unchanged -> CMD_GAP idle cycles -> IDLE.
//   Types 6/7: accepted, nothing issued, err_o at N+1, no gap.
//   Mode update: type 0 -> NORMAL, 1 -> OFF, 2 -> MANUAL.
//   Types 3/4/5 update the matching shadow only when mode==MANUAL.
//  Config FSM: IDLE -> ENTER -> WR_G -> WR_R -> WR_Y -> RESTORE -> GAP -> IDLE. Each step issues at most one command.
//   Issued commands are separated by exactly CMD_GAP+1 cycles.
//   ENTER issues type 2; skipped when mode==MANUAL.
//   WR_G / WR_R / WR_Y issue types 3 / 4 / 5 with the latched data.
//   RESTORE issues type 0 if mode NORMAL, type 1 if OFF, nothing if MANUAL. Mode is unchanged after the sequence.
//   done_o pulses in the cycle of the last issued command, or at N+1 if nothing is issued.
//   The final GAP lasts CMD_GAP cycles; busy_o is high from N+1 until IDLE is re-entered.
//  Arithmetic: a time value of 0 is issued as 1, because the lights treat 0 as wrap-around. Shadows store the issued value.
//  Commands never overlap: at most one cmd_valid_o pulse per CMD_GAP+1 cycles.
//  arst_i mid-sequence: cmd_valid_o drops immediately and the sequence is abandoned; no resume after release.
// CONFIGURATION
//  TL_CFG_SEQ_SKIP_UNCHANGED_EN defined:
//   WR_* steps whose (clamped) value equals the shadow are skipped.
//   If all three are equal, ENTER and RESTORE are also skipped: nothing is issued, done_o pulses at N+1.
//  Undefined: all three writes are always issued; shadows are still maintained.
// STRUCTURE
//  traffic_lights_pkg:
//   - cmd_type_e: CMD_NORMAL=0, CMD_OFF=1, CMD_MANUAL=2, CMD_SET_GREEN=3, CMD_SET_RED=4, CMD_SET_YELLOW=5
//   - mode_e {NORMAL, OFF, MANUAL}
//   - seq_state_e
//   - TL_DEFAULT_TIME = 16'd10
//  Sub-module tl_cmd_rr_arbiter: 2-requester round-robin grant with pointer, enabled only in IDLE.
// TESTING
//  1 cfg 20/30/5, CMD_GAP=1, accept at N -> (2,-)@N+1, (3,20)@N+3, (4,30)@N+5, (5,5)@N+7, (0,-)@N+9.
//    done_o@N+9; cfg_ready_o high again at N+11.
//  2 op type 1, then cfg 20/30/5 -> sequence ends with cmd_type_o=1, not 0; op type 2 then cfg -> no type 2 or final cmd issued.
//  3 op and cfg both valid in the same cycle after reset -> op issued first, then cfg sequence.
//    Repeat with both valid -> cfg wins.
//  4 cfg green=0 -> type 3 issued with cmd_data_o=1; op type 7 -> err_o pulse, no cmd_valid_o.
//  5 arst_i asserted right after the type 3 pulse -> cmd_valid_o=0 with no clock edge.
//    After release: busy_o=0, op_ready_o=1, shadows back to 10.
//  6 With TL_CFG_SEQ_SKIP_UNCHANGED_EN: cfg 10/10/10 after reset -> no cmd_valid_o, done_o@N+1.
//    cfg 10/25/10 -> only (2), (4,25), (0) issued.

Source files
------------

// File: rtl/traffic_lights_pkg.sv
// Shared types and constants for the traffic_lights command sequencer.
package traffic_lights_pkg;

   typedef enum logic [2:0] {
      CMD_NORMAL     = 3'd0,
      CMD_OFF        = 3'd1,
      CMD_MANUAL     = 3'd2,
      CMD_SET_GREEN  = 3'd3,
      CMD_SET_RED    = 3'd4,
      CMD_SET_YELLOW = 3'd5
   } cmd_type_e;

   typedef enum logic [1:0] {NORMAL, OFF, MANUAL} mode_e;

   typedef enum logic [2:0] {
      S_IDLE, S_ENTER, S_WR_G, S_WR_R, S_WR_Y, S_RESTORE, S_OP, S_GAP
   } seq_state_e;

   // Bit positions of the timing-update issue mask, in issue order.
   localparam int STEP_ENTER   = 0;
   localparam int STEP_WR_G    = 1;
   localparam int STEP_WR_R    = 2;
   localparam int STEP_WR_Y    = 3;
   localparam int STEP_RESTORE = 4;
   localparam int NUM_STEPS    = 5;

   localparam logic [15:0] TL_DEFAULT_TIME = 16'd10;

endpackage

// File: rtl/tl_cmd_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer side wins a tie and the pointer
// moves to the other side after every grant.
module tl_cmd_rr_arbiter (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] ready_o,
   output logic [1:0] gnt_o
);

   logic ptr_q;  // 0: requester 0 has priority, 1: requester 1

   always_comb begin
      ready_o = 2'b00;
      if (en_i) begin
         ready_o[0] = !(req_i[0] && req_i[1] && ptr_q);
         ready_o[1] = !(req_i[0] && req_i[1] && !ptr_q);
      end
   end

   assign gnt_o = ready_o & req_i;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ptr_q <= 1'b0;
      end else if (gnt_o[0]) begin
         ptr_q <= 1'b1;
      end else if (gnt_o[1]) begin
         ptr_q <= 1'b0;
      end
   end

endmodule

// File: rtl/traffic_lights_cfg_seq.sv
// Sole command driver for traffic_lights: arbitrates operator commands against atomic timing updates.
// Optional: define TL_CFG_SEQ_SKIP_UNCHANGED_EN to skip writes whose value already matches the shadow.
module traffic_lights_cfg_seq
   import traffic_lights_pkg::*;
#(
   parameter int CMD_GAP = 1,
   parameter int DATA_W  = 16
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  logic [2:0]        op_type_i,
   input  logic [DATA_W-1:0] op_data_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [DATA_W-1:0] cfg_green_i,
   input  logic [DATA_W-1:0] cfg_red_i,
   input  logic [DATA_W-1:0] cfg_yellow_i,
   output logic              cmd_valid_o,
   output logic [2:0]        cmd_type_o,
   output logic [DATA_W-1:0] cmd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int                CNT_W    = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
   localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(CMD_GAP);
   localparam logic [DATA_W-1:0] DEF_TIME = DATA_W'(TL_DEFAULT_TIME);

   seq_state_e             state_q;
   mode_e                  mode_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [NUM_STEPS-1:0]   mask_q;
   logic [DATA_W-1:0]      lat_g_q, lat_r_q, lat_y_q;
   logic [DATA_W-1:0]      sh_g_q, sh_r_q, sh_y_q;
   logic                   cmd_valid_q, done_q, err_q;
   logic [2:0]             cmd_type_q;
   logic [DATA_W-1:0]      cmd_data_q;

   logic [1:0]             rdy, gnt;
   logic                   acc_op, acc_cfg;
   logic [DATA_W-1:0]      g_v, r_v, y_v;
   logic [2:0]             wr;
   logic [NUM_STEPS-1:0]   new_mask, cur_mask, rem_mask;
   int                     step;
   logic                   issue_now;
   seq_state_e             nxt_state;
   logic [2:0]             nxt_type;
   logic [DATA_W-1:0]      nxt_data;

   tl_cmd_rr_arbiter u_arb (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .en_i    (state_q == S_IDLE),
      .req_i   ({cfg_valid_i, op_valid_i}),
      .ready_o (rdy),
      .gnt_o   (gnt)
   );

   assign op_ready_o  = rdy[0];
   assign cfg_ready_o = rdy[1];
   assign acc_op      = gnt[0];
   assign acc_cfg     = gnt[1];

   // The lights treat a time of 0 as wrap-around, so 1 is the shortest programmable time.
   function automatic logic [DATA_W-1:0] clamp_time(input logic [DATA_W-1:0] v);
      return (v == '0) ? DATA_W'(1) : v;
   endfunction

   // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      g_v = acc_cfg ? clamp_time(cfg_green_i)  : lat_g_q;
      r_v = acc_cfg ? clamp_time(cfg_red_i)    : lat_r_q;
      y_v = acc_cfg ? clamp_time(cfg_yellow_i) : lat_y_q;
`ifdef TL_CFG_SEQ_SKIP_UNCHANGED_EN
      wr = {y_v != sh_y_q, r_v != sh_r_q, g_v != sh_g_q};
`else
      wr = 3'b111;
`endif
      new_mask = {(mode_q != MANUAL) && (|wr), wr, (mode_q != MANUAL) && (|wr)};
      cur_mask = acc_cfg ? new_mask : mask_q;
      step     = STEP_RESTORE;
      for (int i = NUM_STEPS - 1; i >= 0; i--) begin
         if (cur_mask[i]) step = i;
      end
      rem_mask  = cur_mask & ~(NUM_STEPS'(1) << step);
      issue_now = acc_cfg ? (|new_mask)
                          : ((state_q inside {S_ENTER, S_WR_G, S_WR_R, S_WR_Y, S_RESTORE})
                             && (cnt_q == '0) && (|mask_q));
      nxt_state = S_RESTORE;
      nxt_type  = (mode_q == OFF) ? CMD_OFF : CMD_NORMAL;
      nxt_data  = '0;
      case (step)
         STEP_ENTER: begin nxt_state = S_ENTER; nxt_type = CMD_MANUAL;     end
         STEP_WR_G:  begin nxt_state = S_WR_G;  nxt_type = CMD_SET_GREEN;  nxt_data = g_v; end
         STEP_WR_R:  begin nxt_state = S_WR_R;  nxt_type = CMD_SET_RED;    nxt_data = r_v; end
         STEP_WR_Y:  begin nxt_state = S_WR_Y;  nxt_type = CMD_SET_YELLOW; nxt_data = y_v; end
         default:    ;
      endcase
   end

`ifndef TL_CFG_SEQ_SKIP_UNCHANGED_EN
   logic shadow_unused;
   assign shadow_unused = ^{sh_g_q, sh_r_q, sh_y_q};
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= S_IDLE;
         mode_q      <= NORMAL;
         cnt_q       <= '0;
         mask_q      <= '0;
         lat_g_q     <= DEF_TIME;
         lat_r_q     <= DEF_TIME;
         lat_y_q     <= DEF_TIME;
         sh_g_q      <= DEF_TIME;
         sh_r_q      <= DEF_TIME;
         sh_y_q      <= DEF_TIME;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= '0;
         cmd_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         if (acc_cfg) begin
            lat_g_q <= g_v;
            lat_r_q <= r_v;
            lat_y_q <= y_v;
         end
         if (issue_now) begin
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= nxt_type;
            cmd_data_q  <= nxt_data;
            state_q     <= nxt_state;
            mask_q      <= rem_mask;
            cnt_q       <= GAP_LOAD;
            done_q      <= (rem_mask == '0);
            case (step)
               STEP_WR_G: sh_g_q <= g_v;
               STEP_WR_R: sh_r_q <= r_v;
               STEP_WR_Y: sh_y_q <= y_v;
               default:   ;
            endcase
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (acc_op) begin
                     if (op_type_i[2:1] == 2'b11) begin
                        err_q <= 1'b1;
                     end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= op_type_i;
                        cmd_data_q  <= op_data_i;
                        state_q     <= S_OP;
                        mask_q      <= '0;
                        cnt_q       <= GAP_LOAD;
                        case (op_type_i)
                           CMD_NORMAL:     mode_q <= NORMAL;
                           CMD_OFF:        mode_q <= OFF;
                           CMD_MANUAL:     mode_q <= MANUAL;
                           CMD_SET_GREEN:  if (mode_q == MANUAL) sh_g_q <= op_data_i;
                           CMD_SET_RED:    if (mode_q == MANUAL) sh_r_q <= op_data_i;
                           CMD_SET_YELLOW: if (mode_q == MANUAL) sh_y_q <= op_data_i;
                           default:        ;
                        endcase
                     end
                  end else if (acc_cfg) begin
                     // Every write was redundant: report completion without touching the port.
                     done_q  <= 1'b1;
                     state_q <= S_RESTORE;
                     mask_q  <= '0;
                     cnt_q   <= GAP_LOAD;
                  end
               end
               S_GAP: begin
                  if (cnt_q == '0) state_q <= S_IDLE;
                  else             cnt_q   <= cnt_q - 1'b1;
               end
               default: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                     if (mask_q == '0) state_q <= S_GAP;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign cmd_valid_o = cmd_valid_q;
   assign cmd_type_o  = cmd_type_q;
   assign cmd_data_o  = cmd_data_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule
